ac_ctrl_seq: RTL and testbench

Instruction sequencer that sits directly upstream of the accumulator register. It accepts one 16-bit basic-computer instruction at a time over a valid/ready handshake, fetches operands over a simple memory request/acknowledge port, and emits one-cycle control strobes (acLD, acINR, acCLR, AND, ADD, CMA, CME, CIR, CIL, CLE). Register-reference micro-ops are serialised one per cycle, because the accumulator applies only one operation per clock by priority. Skip conditions are evaluated on the updated AC/E.

---
 rtl/ac_ctrl_seq.sv | 209 ++++++++++++++++++++
 tb/tb_ac_ctrl_seq.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_ctrl_seq.sv
// Basic-computer instruction sequencer: decodes one instruction, fetches operands, issues one accumulator strobe per cycle.
// Latency: reg-ref n+2 cycles, mem-ref k(+k_ind)+2; instr_ready only in IDLE; memRD/memADDR held until memACK.
module ac_ctrl_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] IR,
    input  logic [15:0] AC,
    input  logic        E,
    output logic        memRD,
    output logic [11:0] memADDR,
    input  logic        memACK,
    input  logic [15:0] memDATA,
    output logic        drLD,
    output logic        acLD,
    output logic        acINR,
    output logic        acCLR,
    output logic        AND,
    output logic        ADD,
    output logic        CMA,
    output logic        CME,
    output logic        CIR,
    output logic        CIL,
    output logic        CLE,
    output logic        done,
    output logic        skip,
    output logic        ill,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE, DECODE, IND, FETCH, EXEC, MICRO, TEST, HALT
    } state_t;

    typedef struct packed {
        logic        ind;
        logic [2:0]  op;
        logic [11:0] addr;
    } instr_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_REG = 3'b111;

    state_t      state_q, state_d;
    instr_t      ir_q, ir_d;
    logic [11:0] ea_q, ea_d;
    // Pending micro-ops from IR[11:5]; bit 6 is CLA, bit 0 is INC.
    logic [6:0]  mask_q, mask_d;
    logic [6:0]  top;
    logic        is_mref;
    logic        is_reg;
    logic        unused_mem_hi;

    assign unused_mem_hi = &{1'b0, memDATA[15:12]};

    assign is_mref = (ir_q.op == OP_AND) || (ir_q.op == OP_ADD) || (ir_q.op == OP_LDA);
    assign is_reg  = (ir_q.op == OP_REG) && !ir_q.ind;

    // Highest pending micro-op wins; later iterations overwrite lower bits.
    always_comb begin
        top = '0;
        for (int b = 0; b < 7; b++) begin
            if (mask_q[b]) begin
                top    = '0;
                top[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ir_q    <= '0;
            ea_q    <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ea_q    <= ea_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ea_d    = ea_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    ir_d    = IR;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_reg) begin
                    mask_d  = ir_q.addr[11:5];
                    state_d = (|ir_q.addr[11:5]) ? MICRO : TEST;
                end else if (is_mref) begin
                    if (ir_q.ind) begin
                        state_d = IND;
                    end else begin
                        ea_d    = ir_q.addr;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = EXEC;
                end
            end
            IND: begin
                if (memACK) begin
                    ea_d    = memDATA[11:0];
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (memACK) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
            end
            MICRO: begin
                mask_d = mask_q & ~top;
                if (mask_d == '0) begin
                    state_d = TEST;
                end
            end
            TEST: begin
                state_d = ir_q.addr[0] ? HALT : IDLE;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        memRD       = 1'b0;
        memADDR     = '0;
        acLD        = 1'b0;
        acINR       = 1'b0;
        acCLR       = 1'b0;
        AND         = 1'b0;
        ADD         = 1'b0;
        CMA         = 1'b0;
        CME         = 1'b0;
        CIR         = 1'b0;
        CIL         = 1'b0;
        CLE         = 1'b0;
        done        = 1'b0;
        skip        = 1'b0;
        ill         = 1'b0;
        halted      = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
            end
            IND: begin
                memRD   = 1'b1;
                memADDR = ir_q.addr;
            end
            FETCH: begin
                memRD   = 1'b1;
                memADDR = ea_q;
            end
            EXEC: begin
                done = 1'b1;
                ill  = !is_mref;
                AND  = (ir_q.op == OP_AND);
                ADD  = (ir_q.op == OP_ADD);
                acLD = (ir_q.op == OP_LDA);
            end
            MICRO: begin
                acCLR = top[6];
                CLE   = top[5];
                CMA   = top[4];
                CME   = top[3];
                CIR   = top[2];
                CIL   = top[1];
                acINR = top[0];
            end
            TEST: begin
                // AC/E are the fed-back values after the last micro-op has landed.
                done = 1'b1;
                skip = (ir_q.addr[4] && !AC[15]) || (ir_q.addr[3] && AC[15]) ||
                       (ir_q.addr[2] && (AC == 16'h0000)) || (ir_q.addr[1] && !E);
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

    assign drLD = (state_q == FETCH) && memACK;

endmodule

// File: tb/tb_ac_ctrl_seq.sv
// Random instruction stream against an accumulator/memory environment; expectations from a
// semantic reference model are queued at issue and checked by a monitor at each done pulse.
module tb_ac_ctrl_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] IR;
    logic [15:0] AC;
    logic        E;
    logic        memRD;
    logic [11:0] memADDR;
    logic        memACK;
    logic [15:0] memDATA;
    logic        drLD, acLD, acINR, acCLR, AND, ADD, CMA, CME, CIR, CIL, CLE;
    logic        done, skip, ill, halted;

    ac_ctrl_seq dut (
        .CLK(CLK), .RST(RST), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .IR(IR), .AC(AC), .E(E), .memRD(memRD), .memADDR(memADDR), .memACK(memACK),
        .memDATA(memDATA), .drLD(drLD), .acLD(acLD), .acINR(acINR), .acCLR(acCLR),
        .AND(AND), .ADD(ADD), .CMA(CMA), .CME(CME), .CIR(CIR), .CIL(CIL), .CLE(CLE),
        .done(done), .skip(skip), .ill(ill), .halted(halted)
    );

    always #5 CLK = ~CLK;

    localparam int S_LD = 9, S_INR = 8, S_CLR = 7, S_AND = 6, S_ADD = 5;
    localparam int S_CMA = 4, S_CME = 3, S_CIR = 2, S_CIL = 1, S_CLE = 0;

    typedef struct packed {
        logic [79:0] stb;
        logic [7:0]  nstb;
        logic [7:0]  lat;
        logic [3:0]  nrd;
        logic        skip;
        logic        ill;
        logic        halt;
    } rec_t;

    wire [9:0] stb_w = {acLD, acINR, acCLR, AND, ADD, CMA, CME, CIR, CIL, CLE};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mem [0:4095];
    rec_t        sb_q[$];
    int          lat_q[$];
    logic [11:0] addr_q[$];
    logic [15:0] m_ac;
    logic        m_e;
    logic        abort_req;
    logic [15:0] ac_env, dr_env;
    logic        e_env;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Accumulator semantics of one strobe; {E,AC} in and out.
    function automatic logic [16:0] do_op(input logic [9:0] c, input logic [16:0] ea, input logic [15:0] dr);
        logic [15:0] a;
        logic        e;
        a = ea[15:0];
        e = ea[16];
        if (c[S_CLR])      a = 16'h0000;
        else if (c[S_LD])  a = dr;
        else if (c[S_AND]) a = a & dr;
        else if (c[S_ADD]) {e, a} = {1'b0, a} + {1'b0, dr};
        else if (c[S_INR]) a = a + 16'd1;
        else if (c[S_CMA]) a = ~a;
        else if (c[S_CLE]) e = 1'b0;
        else if (c[S_CME]) e = ~e;
        else if (c[S_CIR]) {a, e} = {e, a};
        else if (c[S_CIL]) {e, a} = {a, e};
        return {e, a};
    endfunction

    function automatic logic [9:0] micro_code(input int b);
        logic [9:0] c;
        c = '0;
        case (b)
            11: c[S_CLR] = 1'b1;
            10: c[S_CLE] = 1'b1;
            9:  c[S_CMA] = 1'b1;
            8:  c[S_CME] = 1'b1;
            7:  c[S_CIR] = 1'b1;
            6:  c[S_CIL] = 1'b1;
            default: c[S_INR] = 1'b1;
        endcase
        return c;
    endfunction

    // Environment: the accumulator and DR this sequencer drives.
    always @(posedge CLK) begin
        if (RST) begin
            ac_env <= 16'h0000;
            e_env  <= 1'b0;
            dr_env <= 16'h0000;
        end else begin
            if (drLD) dr_env <= memDATA;
            if (stb_w != 10'd0) {e_env, ac_env} <= do_op(stb_w, {e_env, ac_env}, dr_env);
        end
    end
    assign AC = ac_env;
    assign E  = e_env;

    // Reference model: expected trace of one instruction, plus the reads it will make.
    task automatic predict(input logic [15:0] ir, input int k1, input int k2);
        rec_t        r;
        logic [9:0]  c;
        logic [11:0] ea;
        int          n;
        r = '0;
        n = 0;
        if (ir[14:12] == 3'b111 && !ir[15]) begin
            for (int b = 11; b >= 5; b--) begin
                if (ir[b]) begin
                    c = micro_code(b);
                    r.stb[n*10 +: 10] = c;
                    n++;
                    {m_e, m_ac} = do_op(c, {m_e, m_ac}, 16'h0000);
                end
            end
            r.nstb = 8'(n);
            r.lat  = 8'(n + 2);
            r.skip = (ir[4] && !m_ac[15]) || (ir[3] && m_ac[15]) || (ir[2] && m_ac == 16'h0000) || (ir[1] && !m_e);
            r.halt = ir[0];
        end else if (ir[14:12] <= 3'd2) begin
            ea    = ir[11:0];
            r.lat = 8'd2;
            if (ir[15]) begin
                lat_q.push_back(k1);
                addr_q.push_back(ea);
                ea    = mem[ea][11:0];
                r.lat = r.lat + 8'(k1);
            end
            lat_q.push_back(k2);
            addr_q.push_back(ea);
            r.lat = r.lat + 8'(k2);
            c = '0;
            case (ir[14:12])
                3'd0:    c[S_AND] = 1'b1;
                3'd1:    c[S_ADD] = 1'b1;
                default: c[S_LD]  = 1'b1;
            endcase
            r.stb[9:0] = c;
            r.nstb     = 8'd1;
            r.nrd      = 4'd1;
            {m_e, m_ac} = do_op(c, {m_e, m_ac}, mem[ea]);
        end else begin
            r.lat = 8'd2;
            r.ill = 1'b1;
        end
        sb_q.push_back(r);
    endtask

    task automatic offer(input logic [15:0] ir);
        logic ok;
        ok          = 1'b0;
        IR          = ir;
        instr_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge CLK);
            if (instr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK); #1;
        instr_valid = 1'b0;
        IR          = 16'($urandom);
        chk("handshake", ok, 1);
    endtask

    task automatic issue(input logic [15:0] ir, input int k1, input int k2);
        predict(ir, k1, k2);
        offer(ir);
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge CLK); #2;
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", ok, 1);
    endtask

    // Memory responder: ack latencies come from the queue filled at issue time.
    initial begin
        int          k;
        logic [11:0] a;
        memACK  = 1'b0;
        memDATA = 16'h0000;
        forever begin
            if (memRD === 1'b1) begin
                chk("read_expected", lat_q.size() > 0, 1);
                k = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                if (addr_q.size() > 0) chk("mem_addr", memADDR, addr_q.pop_front());
                a = memADDR;
                for (int i = 1; i < k; i++) begin
                    @(posedge CLK); #1;
                    if (!abort_req) begin
                        chk("rd_held", memRD, 1);
                        chk("addr_held", memADDR, a);
                    end
                end
                memDATA = mem[a];
                memACK  = 1'b1;
                @(posedge CLK); #1;
                memACK  = 1'b0;
                memDATA = 16'($urandom);
            end else begin
                @(posedge CLK); #1;
            end
        end
    end

    // Monitor: builds the observed trace since each handshake and scores it at done.
    initial begin
        rec_t o, x;
        bit   active;
        bit   post;
        logic post_halt;
        int   c;
        active = 0; post = 0; post_halt = 1'b0; c = 0; o = '0;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1) begin
                active = 0;
                post   = 0;
            end else begin
                if (post) begin
                    chk("ready_after_done", instr_ready, !post_halt);
                    chk("halted_after_done", halted, post_halt);
                    post = 0;
                end
                if (active) begin
                    c++;
                    chk("one_strobe", $countones(stb_w) > 1, 0);
                    if (stb_w != 10'd0) begin
                        if (o.nstb < 8) o.stb[o.nstb*10 +: 10] = stb_w;
                        o.nstb = o.nstb + 8'd1;
                    end
                    if (drLD) o.nrd = o.nrd + 4'd1;
                    if (done) begin
                        chk("scoreboard_entry", sb_q.size() > 0, 1);
                        if (sb_q.size() > 0) begin
                            x = sb_q.pop_front();
                            chk("done_cycle", c, x.lat);
                            chk("strobe_count", o.nstb, x.nstb);
                            for (int i = 0; i < 8 && i < int'(x.nstb); i++)
                                chk("strobe_seq", o.stb[i*10 +: 10], x.stb[i*10 +: 10]);
                            chk("skip", skip, x.skip);
                            chk("ill", ill, x.ill);
                            chk("drld_count", o.nrd, x.nrd);
                            post      = 1;
                            post_halt = x.halt;
                        end
                        active = 0;
                    end else if (c > 60) begin
                        chk("done_timeout", done, 1);
                        if (sb_q.size() > 0) x = sb_q.pop_front();
                        active = 0;
                    end
                end else begin
                    chk("stray_done", done, 0);
                end
                if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                    active = 1;
                    c      = 0;
                    o      = '0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ir;
        int          cls;
        RST = 1'b1; instr_valid = 1'b0; IR = 16'h0000; abort_req = 1'b0;
        m_ac = 16'h0000; m_e = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[12'h010] = 16'h1234;
        mem[12'h011] = 16'hFFFF;
        mem[12'h045] = 16'h0ABC;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", instr_ready, 1);
        chk("rst_memrd", memRD, 0);
        chk("rst_memaddr", memADDR, 0);
        chk("rst_strobes", stb_w, 0);
        chk("rst_drld", drLD, 0);
        chk("rst_done", done, 0);
        chk("rst_skip", skip, 0);
        chk("rst_ill", ill, 0);
        chk("rst_halted", halted, 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        issue(16'h2010, 0, 1);
        issue(16'h7800, 0, 0);
        issue(16'h2011, 0, 2);
        issue(16'h7230, 0, 0);
        issue(16'h1123, 0, 3);
        issue(16'h8045, 2, 1);
        issue(16'h3000, 0, 0);
        issue(16'hF800, 0, 0);
        issue(16'h7000, 0, 0);
        issue(16'h7001, 0, 0);
        drain();
        IR = 16'h2010; instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            chk("halt_held", halted, 1);
            chk("halt_not_ready", instr_ready, 0);
        end
        @(posedge CLK); #1;
        instr_valid = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        m_ac = 16'h0000; m_e = 1'b0;
        @(negedge CLK);
        chk("halt_cleared", halted, 0);
        chk("ready_after_rst", instr_ready, 1);

        // Reset while FETCH waits; the ack lands one cycle after reset takes effect.
        abort_req = 1'b1;
        lat_q.push_back(3);
        addr_q.push_back(12'h050);
        @(posedge CLK); #1;
        offer(16'h2050);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        m_ac = 16'h0000; m_e = 1'b0;
        @(negedge CLK);
        chk("abort_ack_seen", memACK, 1);
        chk("abort_memrd", memRD, 0);
        chk("abort_drld", drLD, 0);
        chk("abort_strobes", stb_w, 0);
        chk("abort_ready", instr_ready, 1);
        repeat (3) @(posedge CLK);
        #1;
        abort_req = 1'b0;
        chk("abort_reads_consumed", lat_q.size(), 0);
        issue(16'h2045, 0, 2);
        issue(16'h7A04, 0, 0);

        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
            cls = $urandom_range(0, 9);
            if (cls < 4) begin
                ir = 16'h7000 | (16'($urandom) & 16'h0FFE);
            end else if (cls < 8) begin
                ir = {1'($urandom), 3'($urandom_range(0, 2)), 12'($urandom)};
            end else if (cls == 8) begin
                ir = {1'($urandom), 3'($urandom_range(3, 6)), 12'($urandom)};
            end else begin
                ir = {4'hF, 12'($urandom)};
            end
            issue(ir, $urandom_range(1, 4), $urandom_range(1, 4));
        end
        drain();
        chk("reads_consumed", lat_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
